// File: rtl/run_sequencer.sv
// Run controller: delayed go pulse, cycle/overflow measurement, timeout watchdog and result dump.
// Optional RUN_LOG_EN keeps a per-run log of finishing cycle counts.
module run_sequencer #(
    parameter int unsigned ADDR_W     = 7,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned GO_DELAY   = 3,
    parameter int unsigned DUMP_START = 28,
    parameter int unsigned DUMP_END   = 127,
    parameter int unsigned TIMEOUT    = 100000,
    parameter int unsigned NUM_RUNS   = 1
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_start,
    output logic              o_dut_go,
    input  logic              i_dut_finished,
    input  logic              i_dut_overflow,
    output logic              o_rd_sel,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [DATA_W-1:0] i_rd_data,
    output logic              o_dump_valid,
    output logic [ADDR_W-1:0] o_dump_addr,
    output logic [DATA_W-1:0] o_dump_data,
    output logic [CNT_W-1:0]  o_cycle_count,
    output logic [CNT_W-1:0]  o_overflow_count,
    output logic [3:0]        o_run_index,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_timeout_err,
    input  logic [3:0]        i_log_sel,
    output logic [CNT_W-1:0]  o_log_cycles
);

    typedef enum logic [2:0] {StIdle, StWait, StGo, StRun, StDump, StDrain, StDone} state_t;

    state_t             r_state, w_state_n;
    logic [7:0]         r_delay, w_delay_n;
    logic [ADDR_W-1:0]  r_addr, w_addr_n;
    logic [CNT_W-1:0]   r_cycle, w_cycle_n, w_cycle_inc;
    logic [CNT_W-1:0]   r_ovf, w_ovf_n, w_ovf_inc;
    logic [3:0]         r_run_idx, w_run_n;
    logic               r_timeout, w_timeout_n;
    logic               r_done, w_done_n;
    logic               r_dump_valid;
    logic [ADDR_W-1:0]  r_dump_addr;
    logic               w_setup;
    logic               w_log_we;

    assign w_cycle_inc = (&r_cycle) ? r_cycle : r_cycle + CNT_W'(1);
    assign w_ovf_inc   = (&r_ovf) ? r_ovf : r_ovf + CNT_W'(1);

    always_comb begin
        w_state_n   = r_state;
        w_delay_n   = r_delay;
        w_addr_n    = r_addr;
        w_cycle_n   = r_cycle;
        w_ovf_n     = r_ovf;
        w_run_n     = r_run_idx;
        w_timeout_n = r_timeout;
        w_done_n    = 1'b0;
        w_setup     = 1'b0;
        w_log_we    = 1'b0;
        unique case (r_state)
            StIdle, StDone: begin
                // A start landing on the done pulse cycle is dropped.
                if (i_start && !r_done) begin
                    w_timeout_n = 1'b0;
                    w_run_n     = '0;
                    w_setup     = 1'b1;
                end
            end
            StWait: begin
                if (r_delay == 8'd0) begin
                    w_state_n = StGo;
                    w_cycle_n = CNT_W'(1);
                end else begin
                    w_delay_n = r_delay - 8'd1;
                end
            end
            StGo: begin
                w_state_n = StRun;
                w_cycle_n = w_cycle_inc;
                if (i_dut_overflow) w_ovf_n = w_ovf_inc;
            end
            StRun: begin
                if (i_dut_overflow) w_ovf_n = w_ovf_inc;
                if (i_dut_finished) begin
                    w_state_n = StDump;
                    w_addr_n  = ADDR_W'(DUMP_START);
                    w_log_we  = 1'b1;
                end else if (r_cycle == CNT_W'(TIMEOUT)) begin
                    w_state_n   = StDone;
                    w_timeout_n = 1'b1;
                    w_done_n    = 1'b1;
                end else begin
                    w_cycle_n = w_cycle_inc;
                end
            end
            StDump: begin
                if (r_addr == ADDR_W'(DUMP_END)) w_state_n = StDrain;
                else                             w_addr_n  = r_addr + ADDR_W'(1);
            end
            StDrain: begin
                // The final beat is on the outputs this cycle.
                if (r_run_idx < 4'(NUM_RUNS - 1)) begin
                    w_run_n = r_run_idx + 4'd1;
                    w_setup = 1'b1;
                end else begin
                    w_state_n = StDone;
                    w_done_n  = 1'b1;
                end
            end
            default: w_state_n = StIdle;
        endcase
        if (w_setup) begin
            w_ovf_n = '0;
            if (GO_DELAY == 0) begin
                w_state_n = StGo;
                w_cycle_n = CNT_W'(1);
            end else begin
                w_state_n = StWait;
                w_delay_n = 8'(GO_DELAY - 1);
                w_cycle_n = '0;
            end
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= StIdle;
            r_delay      <= '0;
            r_addr       <= '0;
            r_cycle      <= '0;
            r_ovf        <= '0;
            r_run_idx    <= '0;
            r_timeout    <= 1'b0;
            r_done       <= 1'b0;
            r_dump_valid <= 1'b0;
            r_dump_addr  <= '0;
        end else begin
            r_state      <= w_state_n;
            r_delay      <= w_delay_n;
            r_addr       <= w_addr_n;
            r_cycle      <= w_cycle_n;
            r_ovf        <= w_ovf_n;
            r_run_idx    <= w_run_n;
            r_timeout    <= w_timeout_n;
            r_done       <= w_done_n;
            r_dump_valid <= (r_state == StDump);
            r_dump_addr  <= (r_state == StDump) ? r_addr : '0;
        end
    end

    assign o_dut_go         = (r_state == StGo);
    assign o_rd_sel         = (r_state == StDump);
    assign o_rd_addr        = o_rd_sel ? r_addr : '0;
    assign o_dump_valid     = r_dump_valid;
    assign o_dump_addr      = r_dump_addr;
    // The SRAM output register already holds the beat; gate so idle/reset shows 0.
    assign o_dump_data      = r_dump_valid ? i_rd_data : '0;
    assign o_cycle_count    = r_cycle;
    assign o_overflow_count = r_ovf;
    assign o_run_index      = r_run_idx;
    assign o_busy           = (r_state != StIdle) && (r_state != StDone);
    assign o_done           = r_done;
    assign o_timeout_err    = r_timeout;

`ifdef RUN_LOG_EN
    logic [CNT_W-1:0] r_log [NUM_RUNS];

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < NUM_RUNS; i++) r_log[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_RUNS; i++) begin
                if (w_log_we && (r_run_idx == 4'(i))) r_log[i] <= r_cycle;
            end
        end
    end

    always_comb begin
        o_log_cycles = '0;
        for (int i = 0; i < NUM_RUNS; i++) begin
            if (i_log_sel == 4'(i)) o_log_cycles = r_log[i];
        end
    end
`else
    logic w_unused_log;
    assign w_unused_log = ^{i_log_sel, w_log_we};
    assign o_log_cycles = '0;
`endif

endmodule

// File: tb/tb_run_sequencer.sv
// Scoreboard bench for run_sequencer: random overflow/latency stimulus, SRAM model, decoupled monitor.
module tb_run_sequencer;
    localparam int ADDR_W     = 7;
    localparam int DATA_W     = 32;
    localparam int CNT_W      = 32;
    localparam int GO_DELAY   = 3;
    localparam int DUMP_START = 28;
    localparam int DUMP_END   = 127;
    localparam int TIMEOUT    = 200;
    localparam int NUM_RUNS   = 3;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              dut_go;
    logic              finished = 1'b0;
    logic              overflow = 1'b0;
    logic              rd_sel;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data = '0;
    logic              dump_valid;
    logic [ADDR_W-1:0] dump_addr;
    logic [DATA_W-1:0] dump_data;
    logic [CNT_W-1:0]  cycle_count;
    logic [CNT_W-1:0]  overflow_count;
    logic [3:0]        run_index;
    logic              busy;
    logic              done;
    logic              timeout_err;
    logic [3:0]        log_sel = '0;
    logic [CNT_W-1:0]  log_cycles;

    run_sequencer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .GO_DELAY(GO_DELAY),
        .DUMP_START(DUMP_START), .DUMP_END(DUMP_END), .TIMEOUT(TIMEOUT), .NUM_RUNS(NUM_RUNS)
    ) dut (
        .i_clock(clock), .i_reset(reset), .i_start(start), .o_dut_go(dut_go),
        .i_dut_finished(finished), .i_dut_overflow(overflow), .o_rd_sel(rd_sel),
        .o_rd_addr(rd_addr), .i_rd_data(rd_data), .o_dump_valid(dump_valid),
        .o_dump_addr(dump_addr), .o_dump_data(dump_data), .o_cycle_count(cycle_count),
        .o_overflow_count(overflow_count), .o_run_index(run_index), .o_busy(busy),
        .o_done(done), .o_timeout_err(timeout_err), .i_log_sel(log_sel),
        .o_log_cycles(log_cycles)
    );

    always #5 clock = ~clock;

    logic [DATA_W-1:0] mem [128];
    always @(posedge clock) rd_data <= mem[rd_addr];

    typedef struct { logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d; } beat_t;
    typedef struct { int cyc; int ovf; int idx; } run_t;
    beat_t beat_q[$];
    run_t  run_q[$];
    bit    done_q[$];
    int    n_checks = 0;
    int    n_pass = 0;
    int    exp_log[NUM_RUNS];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Monitor: pops expectations whenever the DUT presents a beat or a done pulse.
    bit    prev_last = 1'b0;
    beat_t mb;
    run_t  mr;
    bit    mt;
    always @(negedge clock) begin
        if (!reset) begin
            if (done) begin
                if (done_q.size() == 0) check("done without expectation", done, 0);
                else begin
                    mt = done_q.pop_front();
                    check("timeout_err at done", timeout_err, mt);
                    if (!mt) check("done one cycle after last beat", prev_last, 1);
                end
            end
            if (dump_valid) begin
                if (beat_q.size() == 0) check("dump beat without expectation", dump_valid, 0);
                else begin
                    mb = beat_q.pop_front();
                    check("dump_addr", dump_addr, mb.a);
                    check("dump_data", dump_data, mb.d);
                    if (mb.a == ADDR_W'(DUMP_START) && run_q.size() != 0) begin
                        mr = run_q.pop_front();
                        check("cycle_count of run", cycle_count, mr.cyc);
                        check("overflow_count of run", overflow_count, mr.ovf);
                        check("run_index during dump", run_index, mr.idx);
                    end
                end
            end
            prev_last = dump_valid && (dump_addr == ADDR_W'(DUMP_END));
        end else begin
            prev_last = 1'b0;
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, " dut_go"}, dut_go, 0);
        check({tag, " rd_sel"}, rd_sel, 0);
        check({tag, " rd_addr"}, rd_addr, 0);
        check({tag, " dump_valid"}, dump_valid, 0);
        check({tag, " dump_data"}, dump_data, 0);
        check({tag, " cycle_count"}, cycle_count, 0);
        check({tag, " overflow_count"}, overflow_count, 0);
        check({tag, " run_index"}, run_index, 0);
        check({tag, " busy"}, busy, 0);
        check({tag, " done"}, done, 0);
        check({tag, " timeout_err"}, timeout_err, 0);
        check({tag, " log_cycles"}, log_cycles, 0);
    endtask

    // Issues start, injects ignored finished/overflow during WAIT, ends in the GO cycle.
    task automatic start_campaign();
        int cyc;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("busy one cycle after start", busy, 1);
        check("timeout_err cleared by start", timeout_err, 0);
        check("run_index cleared by start", run_index, 0);
        finished = 1'b1;
        overflow = 1'b1;
        cyc = 1;
        while (!dut_go && cyc < 50) begin
            @(negedge clock);
            finished = 1'b0;
            overflow = 1'b0;
            cyc++;
        end
        finished = 1'b0;
        overflow = 1'b0;
        check("start to dut_go latency", cyc, GO_DELAY + 1);
    endtask

    task automatic do_run(input int idx, input int lat, input bit fixed_ovf, input bit poke_start,
                          input bit push_done);
        int n;
        int n_ovf;
        bit o;
        n = 0;
        while (!dut_go && n < 400) begin
            @(negedge clock);
            n++;
        end
        check("dut_go seen", dut_go, 1);
        check("run_index at go", run_index, idx);
        check("cycle_count in GO cycle", cycle_count, 1);
        o = fixed_ovf ? 1'b0 : 1'($urandom_range(0, 1));
        overflow = o;
        n_ovf = int'(o);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clock);
            if (k == 1) check("dut_go lasts one cycle", dut_go, 0);
            o = fixed_ovf ? (k >= 5 && k <= 7) : 1'($urandom_range(0, 1));
            overflow = o;
            n_ovf += int'(o);
            start = poke_start && (k == 2);
            finished = (k == lat);
        end
        @(negedge clock);
        overflow = 1'b0;
        finished = 1'b0;
        start = 1'b0;
        run_q.push_back('{lat + 1, n_ovf, idx});
        for (int a = DUMP_START; a <= DUMP_END; a++) beat_q.push_back('{ADDR_W'(a), mem[a]});
        if (push_done) done_q.push_back(1'b0);
`ifdef RUN_LOG_EN
        exp_log[idx] = lat + 1;
`endif
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 1000) begin
            @(negedge clock);
            n++;
        end
        check("campaign returns to idle", busy, 0);
    endtask

    task automatic check_log();
        for (int s = 0; s < NUM_RUNS; s++) begin
            log_sel = 4'(s);
            #1;
            check("log_cycles", log_cycles, exp_log[s]);
        end
        log_sel = 4'd5;
        #1;
        check("log_cycles out of range", log_cycles, 0);
    endtask

    task automatic random_campaign();
        start_campaign();
        for (int r = 0; r < NUM_RUNS; r++)
            do_run(r, $urandom_range(5, 40), 1'b0, r == 1, r == NUM_RUNS - 1);
        wait_idle();
    endtask

    initial begin
        int n;
        for (int i = 0; i < 128; i++) mem[i] = $urandom;
        for (int i = 0; i < NUM_RUNS; i++) exp_log[i] = 0;
        repeat (2) @(negedge clock);
        check_all_zero("reset");
        reset = 1'b0;

        // Run 0: 50-cycle latency, exactly three overflow cycles; start poked mid-run.
        start_campaign();
        do_run(0, 50, 1'b1, 1'b1, 1'b0);
        do_run(1, $urandom_range(5, 40), 1'b0, 1'b0, 1'b0);
        do_run(2, $urandom_range(5, 40), 1'b0, 1'b0, 1'b1);
        wait_idle();
        check_log();

        start_campaign();
        do_run(0, 10, 1'b0, 1'b0, 1'b0);
        do_run(1, 20, 1'b0, 1'b0, 1'b0);
        do_run(2, 30, 1'b0, 1'b0, 1'b1);
        wait_idle();
        check_log();

        // Timeout: finished never arrives.
        start_campaign();
        done_q.push_back(1'b1);
        n = 0;
        while (!done && n < 300) begin
            @(negedge clock);
            n++;
        end
        check("timeout done seen", done, 1);
        check("cycle_count at timeout", cycle_count, TIMEOUT);
        repeat (3) @(negedge clock);
        check("timeout_err sticky", timeout_err, 1);
        check("idle after timeout", busy, 0);

        // Reset in the middle of a dump.
        start_campaign();
        do_run(0, 15, 1'b0, 1'b0, 1'b0);
        repeat (10) @(negedge clock);
        check("in dump before reset", rd_sel, 1);
        reset = 1'b1;
        #1;
        beat_q.delete();
        run_q.delete();
        done_q.delete();
        for (int i = 0; i < NUM_RUNS; i++) exp_log[i] = 0;
        check_all_zero("mid-dump reset");
        @(negedge clock);
        reset = 1'b0;

        random_campaign();
        check_log();
        repeat (5) @(negedge clock);
        check("scoreboard drained", beat_q.size() + run_q.size() + done_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", n_pass, n_checks);
        $fatal(1);
    end
endmodule
